// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
//
// Shares a single-port register bank between two requesters: port 0 (UART
// command dispatcher) and port 1 (status/debug sequencer). Requests are
// arbitrated round-robin. Each granted transaction issues exactly one write
// or read strobe to the bank. Reads wait out the bank latency, and the read
// data is returned to the port that owns the transaction.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req/we/addr/wdata{0,1} requester inputs; held stable until gnt
//   gnt{0,1}               one-cycle pulse, request accepted
//   rvalid{0,1}            one-cycle pulse, rdata valid
//   rdata{0,1}             read data, held until that port's next read completes
//   mem_addr               bank address; holds its last value when idle
//   mem_write_en/data      bank write strobe and data
//   mem_read_en            bank read strobe
//   mem_read_data          bank read data, valid READ_LAT cycles after the strobe
//   busy                   high whenever the FSM is not in IDLE
//   contention_cnt         saturating count of IDLE cycles with both req high
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data,

  output logic              busy,
  output logic [CNT_W-1:0]  contention_cnt
);

  // Wide enough to hold READ_LAT itself (READ_LAT >= 1 gives at least 1 bit).
  localparam int LAT_W = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             prio_ptr;   // 0: port 0 wins a tie, 1: port 1 wins a tie
  logic             owner;      // port that owns the in-flight transaction
  logic             op_we;      // in-flight transaction is a write
  logic [LAT_W-1:0] lat_cnt;

  // Arbitration decision for the current IDLE cycle.
  logic             any_req;
  logic             pick1;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    any_req   = req0 | req1;
    // Port 1 wins when it is alone, or when both ask and the pointer favours it.
    pick1     = req1 & (~req0 | prio_ptr);
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  // Strobes and grants are registered on the IDLE->ISSUE edge, so they are
  // visible exactly during the ISSUE cycle.
  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // a blocking assignment would let later statements see the new value
  // within the same edge and break the register-to-register timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prio_ptr       <= 1'b0;
      owner          <= 1'b0;
      op_we          <= 1'b0;
      lat_cnt        <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_addr       <= '0;
      mem_write_en   <= 1'b0;
      mem_write_data <= '0;
      mem_read_en    <= 1'b0;
      busy           <= 1'b0;
      contention_cnt <= '0;
    end else begin
      // Pulse outputs default low; the state that needs them raises them.
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= pick1;
            op_we        <= sel_we;
            mem_addr     <= sel_addr;
            gnt0         <= ~pick1;
            gnt1         <= pick1;
            mem_write_en <= sel_we;
            mem_read_en  <= ~sel_we;
            if (sel_we) begin
              mem_write_data <= sel_wdata;
            end
            if (req0 && req1 && (contention_cnt != {CNT_W{1'b1}})) begin
              contention_cnt <= contention_cnt + 1'b1;
            end
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          prio_ptr <= ~owner;
          if (op_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_W'(READ_LAT);
            state   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // lat_cnt == 1 marks the cycle in which the bank data is valid.
          if (lat_cnt == LAT_W'(1)) begin
            if (owner) begin
              rdata1  <= mem_read_data;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_read_data;
              rvalid0 <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Directed bench for reg_access_arbiter. Two instances are built: dut with
// READ_LAT=1 and dut3 with READ_LAT=3, each attached to its own small bank
// model. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- dut (READ_LAT = 1) ----------------
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, rvalid0, gnt1, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_write_data, mem_read_data;
  logic       mem_write_en, mem_read_en, busy;
  logic [15:0] contention_cnt;

  reg_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data),
    .busy(busy), .contention_cnt(contention_cnt)
  );

  // Bank model, 1-cycle read latency. Reset loads bank[i] = i ^ 0x5A.
  logic [7:0] bank [256];
  logic [7:0] bank_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank[i] <= 8'(i) ^ 8'h5A;
      bank_q <= 8'h00;
    end else begin
      if (mem_write_en) bank[mem_addr] <= mem_write_data;
      bank_q <= mem_read_en ? bank[mem_addr] : 8'h00;
    end
  end
  assign mem_read_data = bank_q;

  // ---------------- dut3 (READ_LAT = 3) ----------------
  logic       c_req0, c_we0, c_req1, c_we1;
  logic [7:0] c_addr0, c_wdata0, c_addr1, c_wdata1;
  logic       c_gnt0, c_rvalid0, c_gnt1, c_rvalid1;
  logic [7:0] c_rdata0, c_rdata1;
  logic [7:0] c_mem_addr, c_mem_write_data, c_mem_read_data;
  logic       c_mem_write_en, c_mem_read_en, c_busy;
  logic [15:0] c_contention_cnt;

  reg_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst),
    .req0(c_req0), .we0(c_we0), .addr0(c_addr0), .wdata0(c_wdata0),
    .gnt0(c_gnt0), .rvalid0(c_rvalid0), .rdata0(c_rdata0),
    .req1(c_req1), .we1(c_we1), .addr1(c_addr1), .wdata1(c_wdata1),
    .gnt1(c_gnt1), .rvalid1(c_rvalid1), .rdata1(c_rdata1),
    .mem_addr(c_mem_addr), .mem_write_en(c_mem_write_en),
    .mem_write_data(c_mem_write_data), .mem_read_en(c_mem_read_en),
    .mem_read_data(c_mem_read_data),
    .busy(c_busy), .contention_cnt(c_contention_cnt)
  );

  // Bank model, 3-cycle read latency. Reset loads bank3[i] = i ^ 0x43,
  // so bank3[0x7F] = 0x3C. Data is non-zero only in the valid cycle.
  logic [7:0] bank3 [256];
  logic [7:0] p0, p1, p2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank3[i] <= 8'(i) ^ 8'h43;
      p0 <= 8'h00;
      p1 <= 8'h00;
      p2 <= 8'h00;
    end else begin
      if (c_mem_write_en) bank3[c_mem_addr] <= c_mem_write_data;
      p0 <= c_mem_read_en ? bank3[c_mem_addr] : 8'h00;
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign c_mem_read_data = p2;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    c_req0 = 1'b0; c_we0 = 1'b0; c_addr0 = 8'h00; c_wdata0 = 8'h00;
    c_req1 = 1'b0; c_we1 = 1'b0; c_addr1 = 8'h00; c_wdata1 = 8'h00;
    step(2);

    // ---- reset state ----
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_contention", 32'(contention_cnt), 32'd0);
    rst = 1'b0;
    step();

    // ---- port 0 writes 0xA5 to 0x10 ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    step();  // N+1
    check("wr_gnt0", 32'(gnt0), 32'd1);
    check("wr_gnt1", 32'(gnt1), 32'd0);
    check("wr_we", 32'(mem_write_en), 32'd1);
    check("wr_re", 32'(mem_read_en), 32'd0);
    check("wr_addr", 32'(mem_addr), 32'h10);
    check("wr_data", 32'(mem_write_data), 32'hA5);
    check("wr_busy_issue", 32'(busy), 32'd1);
    req0 = 1'b0;
    step();  // N+2
    check("wr_busy_done", 32'(busy), 32'd0);
    check("wr_pulses_low", {28'd0, gnt0, gnt1, mem_write_en, mem_read_en}, 32'd0);
    check("wr_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check("wr_contention", 32'(contention_cnt), 32'd0);

    // ---- port 0 reads 0x10, bank returns 0xA5 ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    step();  // N+1
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_re", 32'(mem_read_en), 32'd1);
    check("rd_we", 32'(mem_write_en), 32'd0);
    check("rd_addr", 32'(mem_addr), 32'h10);
    req0 = 1'b0;
    step();  // N+2
    check("rd_rvalid0_early", 32'(rvalid0), 32'd0);
    check("rd_busy_wait", 32'(busy), 32'd1);
    step();  // N+3
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_rdata0", 32'(rdata0), 32'hA5);
    check("rd_rvalid1", 32'(rvalid1), 32'd0);
    check("rd_rdata1", 32'(rdata1), 32'd0);
    check("rd_busy_done", 32'(busy), 32'd0);
    step();
    check("rd_rvalid0_pulse", 32'(rvalid0), 32'd0);
    check("rd_rdata0_hold", 32'(rdata0), 32'hA5);
    check("rd_addr_hold", 32'(mem_addr), 32'h10);

    // ---- reset, then both ports request together ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_contention", 32'(contention_cnt), 32'd0);
    check("rst2_rdata0", 32'(rdata0), 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h02; wdata0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h03;
    step();
    check("both_gnt0", 32'(gnt0), 32'd1);
    check("both_gnt1_first", 32'(gnt1), 32'd0);
    check("both_cnt1", 32'(contention_cnt), 32'd1);
    check("both_wr_addr", 32'(mem_addr), 32'h02);
    check("both_wr_data", 32'(mem_write_data), 32'h01);
    req0 = 1'b0;
    step();  // IDLE: samples port 1 alone
    check("both_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    step();
    check("both_gnt1", 32'(gnt1), 32'd1);
    check("both_rd_en", 32'(mem_read_en), 32'd1);
    check("both_rd_addr", 32'(mem_addr), 32'h03);
    check("both_cnt_still1", 32'(contention_cnt), 32'd1);
    req1 = 1'b0;
    step(2);
    check("both_rvalid1", 32'(rvalid1), 32'd1);
    check("both_rdata1", 32'(rdata1), 32'h59);  // 0x03 ^ 0x5A
    check("both_rvalid0", 32'(rvalid0), 32'd0);
    check("both_rdata0", 32'(rdata0), 32'd0);
    step();

    // ---- both hold req for 6 writes: grants alternate 0,1,0,1,0,1 ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h22;
    for (int t = 0; t < 6; t++) begin
      step();  // ISSUE
      check($sformatf("rr_gnt_t%0d", t), {30'd0, gnt1, gnt0},
            (t % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr_addr_t%0d", t), 32'(mem_addr),
            (t % 2 == 0) ? 32'h20 : 32'h21);
      if (t == 5) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();  // IDLE
      check($sformatf("rr_gap_t%0d", t), {30'd0, gnt1, gnt0}, 32'd0);
    end
    step();
    check("rr_contention", 32'(contention_cnt), 32'd7);
    check("rr_busy", 32'(busy), 32'd0);

    // ---- dut3: port 1 reads 0x7F, bank returns 0x3C after 3 cycles ----
    c_req1 = 1'b1; c_we1 = 1'b0; c_addr1 = 8'h7F;
    for (int k = 1; k <= 5; k++) begin
      step();  // N+k
      if (k == 1) begin
        check("l3_gnt1", 32'(c_gnt1), 32'd1);
        check("l3_re", 32'(c_mem_read_en), 32'd1);
        c_req1 = 1'b0;
      end else begin
        check($sformatf("l3_rvalid1_n%0d", k), 32'(c_rvalid1), (k == 5) ? 32'd1 : 32'd0);
        check($sformatf("l3_busy_n%0d", k), 32'(c_busy), (k == 5) ? 32'd0 : 32'd1);
      end
    end
    check("l3_rdata1", 32'(c_rdata1), 32'h3C);
    check("l3_port0", {21'd0, c_gnt0, c_rvalid0, c_rdata0, c_mem_write_en}, 32'd0);
    check("l3_wdata", 32'(c_mem_write_data), 32'd0);
    check("l3_addr", 32'(c_mem_addr), 32'h7F);
    check("l3_contention", 32'(c_contention_cnt), 32'd0);
    step();
    check("l3_rvalid1_pulse", 32'(c_rvalid1), 32'd0);

    // ---- reset during RD_WAIT aborts the read ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    step();  // ISSUE, owner 0 -> pointer moves to port 1
    check("ab_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step();  // RD_WAIT
    check("ab_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("ab_pulses", {26'd0, gnt0, gnt1, rvalid0, rvalid1, mem_write_en, mem_read_en}, 32'd0);
    check("ab_busy_rst", 32'(busy), 32'd0);
    check("ab_addr", 32'(mem_addr), 32'd0);
    check("ab_wdata", 32'(mem_write_data), 32'd0);
    check("ab_rdata", {16'd0, rdata1, rdata0}, 32'd0);
    check("ab_contention", 32'(contention_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ab_no_rvalid_%0d", k), {30'd0, rvalid1, rvalid0}, 32'd0);
    end
    // Pointer must be back at port 0.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h77;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h41; wdata1 = 8'h88;
    step();
    check("ab_prio_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    check("ab_prio_cnt", 32'(contention_cnt), 32'd1);
    req0 = 1'b0;
    step(2);
    check("ab_second_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    check("ab_second_data", 32'(mem_write_data), 32'h88);
    req1 = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
